// File: rtl/seg7_scan_history.sv
// Captures registered sums into a DIGITS-deep history (newest in slot 0) and scans them onto a 7-seg display.
// Latency: one cycle from scan state/history to seg/an; a write is visible on seg the cycle after its edge.
// Backpressure: none; the write strobe is always accepted, and clr overrides a simultaneous write.
module seg7_scan_history #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                         c,
  input  logic                         r_n,
  input  logic [3:0]                   d,
  input  logic                         w,
  input  logic                         clr,
  output logic [6:0]                   seg,
  output logic [DIGITS-1:0]            an,
  output logic [$clog2(DIGITS+1)-1:0]  cnt
);

  localparam int P_W   = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(DIGITS+1);

  // Segment pattern for one hex digit, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [3:0]        hist_q [DIGITS];
  logic [3:0]        hist_d [DIGITS];
  logic [DIGITS-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [P_W-1:0]    p_q, p_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  // History shift / clear: clr discards any same-cycle write.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) hist_d[i] = hist_q[i];
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (clr) begin
      for (int i = 0; i < DIGITS; i++) hist_d[i] = 4'h0;
      valid_d = '0;
      cnt_d   = '0;
    end else if (w) begin
      hist_d[0] = d;
      for (int i = 1; i < DIGITS; i++) hist_d[i] = hist_q[i-1];
      valid_d = {valid_q[DIGITS-2:0], 1'b1};
      cnt_d   = (cnt_q == CNT_W'(DIGITS)) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Free-running scan: prescaler steps the digit index once per slot, independent of w/clr.
  always_comb begin
    p_d   = p_q + 1'b1;
    idx_d = idx_q;
    if (p_q == P_W'(PRESCALE - 1)) begin
      p_d   = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Display decode: the first cycle of every slot is dark to hide ghosting between digits.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h00;
    if (p_q != '0) begin
      an_d[idx_q] = 1'b0;
      seg_d       = valid_q[idx_q] ? hex7(hist_q[idx_q]) : 7'h00;
    end
  end

  // State and output registers.
  always_ff @(posedge c or negedge r_n) begin
    if (!r_n) begin
      for (int i = 0; i < DIGITS; i++) hist_q[i] <= 4'h0;
      valid_q <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h00;
      an_q    <= '1;
    end else begin
      for (int i = 0; i < DIGITS; i++) hist_q[i] <= hist_d[i];
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign cnt = cnt_q;

endmodule
